// File: rtl/dot_product_row_feeder_pkg.sv
// Shared types and constants for the dot-product row feeder: FSM states,
// hold length and default widths.
package dot_product_row_feeder_pkg;

    localparam int NO_OF_UNITS_DEFAULT   = 8;
    localparam int ELEMENT_WIDTH_DEFAULT = 32;
    localparam int ADDR_WIDTH_DEFAULT    = 10;
    localparam int HOLD_CYCLES           = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_RESET,
        ST_FETCH,
        ST_LOAD,
        ST_HOLD,
        ST_WAIT_ROW,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    // A zero-length row still carries one package to the engine.
    function automatic logic [31:0] clamp_packages(input logic [31:0] n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/dot_product_row_feeder_if.sv
// Row interface between the feeder (master) and the dot-product engine (slave).
interface dot_product_row_feeder_if #(
    parameter int no_of_units   = 8,
    parameter int element_width = 32
);

    logic [element_width*no_of_units-1:0] first_row_input;
    logic [element_width*no_of_units-1:0] second_row_input;
    logic                                 outsider_read_now;
    logic                                 reset;
    logic [31:0]                          no_of_multiples;
    logic                                 prepare_my_new_input;
    logic                                 result_strobe;
    logic [element_width-1:0]             dot_product_output;

    modport master (
        output first_row_input, second_row_input, outsider_read_now, reset, no_of_multiples,
        input  prepare_my_new_input, result_strobe, dot_product_output
    );

    modport slave (
        input  first_row_input, second_row_input, outsider_read_now, reset, no_of_multiples,
        output prepare_my_new_input, result_strobe, dot_product_output
    );

endinterface

// File: rtl/dot_product_row_feeder_collector.sv
// Captures engine row results independently of the feed FSM, numbers them
// and flags any strobe that arrives once the job has all its results.
module row_result_collector #(
    parameter int element_width = 32
) (
    input  logic                     clk,
    input  logic                     main_reset,
    input  logic                     job_start,
    input  logic                     active,
    input  logic                     result_strobe,
    input  logic [element_width-1:0] dot_product_output,
    input  logic [15:0]              row_total,
    output logic                     result_valid,
    output logic [element_width-1:0] result_data,
    output logic [15:0]              result_index,
    output logic [15:0]              result_count,
    output logic                     overflow_err
);

    logic full;
    assign full = (result_count == row_total);

    always_ff @(posedge clk) begin
        if (!main_reset) begin
            result_valid <= 1'b0;
            result_data  <= '0;
            result_index <= '0;
            result_count <= '0;
            overflow_err <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (result_strobe && (!active || full)) begin
                overflow_err <= 1'b1;
            end
            if (job_start) begin
                result_count <= '0;
            end else if (result_strobe && active && !full) begin
                result_data  <= dot_product_output;
                result_index <= result_count;
                result_valid <= 1'b1;
                result_count <= result_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/dot_product_row_feeder.sv
// Streams paired row packages from two synchronous-read memories into the
// dot-product engine, one row at a time, and collects the per-row results.
module dot_product_row_feeder
    import dot_product_row_feeder_pkg::*;
#(
    parameter int no_of_units   = NO_OF_UNITS_DEFAULT,
    parameter int element_width = ELEMENT_WIDTH_DEFAULT,
    parameter int addr_width    = ADDR_WIDTH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 main_reset,
    input  logic                                 start,
    input  logic [15:0]                          row_count,
    input  logic [31:0]                          packages_per_row,
    output logic [addr_width-1:0]                mem_addr,
    output logic                                 mem_rd,
    input  logic [element_width*no_of_units-1:0] mem_first_data,
    input  logic [element_width*no_of_units-1:0] mem_second_data,
    dot_product_row_feeder_if.master             eng,
    output logic                                 result_valid,
    output logic [element_width-1:0]             result_data,
    output logic [15:0]                          result_index,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow_err
);

    localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

    feeder_state_t         state;
    logic [15:0]           rows_total;
    logic [15:0]           rows_done;
    logic [31:0]           pkgs_total;
    logic [31:0]           pkgs_done;
    logic [1:0]            hold_cnt;
    logic [addr_width-1:0] addr_cnt;
    logic [15:0]           result_count;
    logic                  job_start;

    assign job_start = (state == ST_IDLE) && start;

    // Outputs are registered on the transition into the state that owns them,
    // so each strobe is high for exactly the cycle the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (!main_reset) begin
            state                 <= ST_IDLE;
            rows_total            <= '0;
            rows_done             <= '0;
            pkgs_total            <= '0;
            pkgs_done             <= '0;
            hold_cnt              <= '0;
            addr_cnt              <= '0;
            mem_addr              <= '0;
            mem_rd                <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            eng.first_row_input   <= '0;
            eng.second_row_input  <= '0;
            eng.outsider_read_now <= 1'b0;
            eng.reset             <= 1'b0;
            eng.no_of_multiples   <= '0;
        end else begin
            eng.reset             <= 1'b0;
            eng.outsider_read_now <= 1'b0;
            mem_rd                <= 1'b0;
            done                  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_total <= row_count;
                        pkgs_total <= clamp_packages(packages_per_row);
                        rows_done  <= '0;
                        pkgs_done  <= '0;
                        addr_cnt   <= '0;
                        busy       <= 1'b1;
                        if (row_count == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state               <= ST_ROW_RESET;
                            eng.reset           <= 1'b1;
                            eng.no_of_multiples <= clamp_packages(packages_per_row);
                        end
                    end
                end
                ST_ROW_RESET: begin
                    eng.no_of_multiples <= '0;
                    pkgs_done           <= '0;
                    mem_rd              <= 1'b1;
                    mem_addr            <= addr_cnt;
                    state               <= ST_FETCH;
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    eng.first_row_input   <= mem_first_data;
                    eng.second_row_input  <= mem_second_data;
                    eng.outsider_read_now <= 1'b1;
                    addr_cnt              <= addr_cnt + 1'b1;
                    pkgs_done             <= pkgs_done + 32'd1;
                    hold_cnt              <= '0;
                    state                 <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (pkgs_done < pkgs_total) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= addr_cnt;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_WAIT_ROW;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end
                ST_WAIT_ROW: begin
                    if (eng.prepare_my_new_input) begin
                        rows_done <= rows_done + 16'd1;
                        if (rows_done + 16'd1 < rows_total) begin
                            state               <= ST_ROW_RESET;
                            eng.reset           <= 1'b1;
                            eng.no_of_multiples <= pkgs_total;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (result_count == rows_total) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    row_result_collector #(
        .element_width(element_width)
    ) u_collector (
        .clk               (clk),
        .main_reset        (main_reset),
        .job_start         (job_start),
        .active            (state != ST_IDLE),
        .result_strobe     (eng.result_strobe),
        .dot_product_output(eng.dot_product_output),
        .row_total         (rows_total),
        .result_valid      (result_valid),
        .result_data       (result_data),
        .result_index      (result_index),
        .result_count      (result_count),
        .overflow_err      (overflow_err)
    );

endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Directed and randomized jobs against the row feeder, with a small engine and
// memory model in the bench and an address/result reference computed per job.
module tb_dot_product_row_feeder;
    import dot_product_row_feeder_pkg::*;

    localparam int NU  = 8;
    localparam int EW  = 32;
    localparam int AW  = 10;
    localparam int AWW = 3;
    localparam int BW  = NU * EW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          main_reset;
    logic          start;
    logic [15:0]   row_count;
    logic [31:0]   packages_per_row;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [BW-1:0] mem_first_data;
    logic [BW-1:0] mem_second_data;
    logic          result_valid;
    logic [EW-1:0] result_data;
    logic [15:0]   result_index;
    logic          busy;
    logic          done;
    logic          overflow_err;

    logic [AWW-1:0] w_mem_addr;
    logic           w_mem_rd;
    logic           w_result_valid;
    logic [EW-1:0]  w_result_data;
    logic [15:0]    w_result_index;
    logic           w_busy;
    logic           w_done;
    logic           w_overflow_err;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] mem_a [1<<AW];
    logic [BW-1:0] mem_b [1<<AW];

    dot_product_row_feeder_if #(.no_of_units(NU), .element_width(EW)) eng ();
    dot_product_row_feeder_if #(.no_of_units(NU), .element_width(EW)) eng_w ();

    assign eng_w.prepare_my_new_input = eng.prepare_my_new_input;
    assign eng_w.result_strobe        = eng.result_strobe;
    assign eng_w.dot_product_output   = eng.dot_product_output;

    dot_product_row_feeder #(.no_of_units(NU), .element_width(EW), .addr_width(AW)) dut (
        .clk(clk), .main_reset(main_reset), .start(start), .row_count(row_count),
        .packages_per_row(packages_per_row), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_first_data(mem_first_data), .mem_second_data(mem_second_data), .eng(eng),
        .result_valid(result_valid), .result_data(result_data), .result_index(result_index),
        .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    // Narrow-address twin: same stimulus, only its address wrap is observed.
    dot_product_row_feeder #(.no_of_units(NU), .element_width(EW), .addr_width(AWW)) dut_wrap (
        .clk(clk), .main_reset(main_reset), .start(start), .row_count(row_count),
        .packages_per_row(packages_per_row), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
        .mem_first_data('0), .mem_second_data('0), .eng(eng_w),
        .result_valid(w_result_valid), .result_data(w_result_data), .result_index(w_result_index),
        .busy(w_busy), .done(w_done), .overflow_err(w_overflow_err)
    );

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_first_data  <= mem_a[mem_addr];
            mem_second_data <= mem_b[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed, input logic [BW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One job: the bench plays engine, checks every strobe against the row/package
    // address rule and the queue of results it handed to the DUT.
    task automatic applyStimulus(input int rows, input int ppr, input bit early_prep,
                                 input bit fixed_res, input bit restart_mid);
        int ppr_eff;
        int exp_addr[$];
        logic [EW-1:0] exp_res[$];
        logic [EW-1:0] val;
        int k, budget, resets, nows, row_nows, reals, done_k, done_cnt, res_seen, rd_i;
        int prep_cd, strobe_cd;
        bit finished;
        ppr_eff = (ppr == 0) ? 1 : ppr;
        for (int r = 0; r < rows; r++) begin
            for (int p = 0; p < ppr_eff; p++) begin
                int a;
                a = r * ppr_eff + p;
                exp_addr.push_back(a);
                if (!fixed_res) begin
                    for (int e = 0; e < NU; e++) begin
                        mem_a[a % (1<<AW)][e*EW +: EW] = $urandom;
                        mem_b[a % (1<<AW)][e*EW +: EW] = $urandom;
                    end
                end
            end
        end
        resets = 0; nows = 0; row_nows = 0; reals = 0; done_k = 0; done_cnt = 0;
        res_seen = 0; rd_i = 0; prep_cd = 0; strobe_cd = 0; finished = 0;
        budget = 100 + rows * (ppr_eff * 5 + 20);

        @(negedge clk);
        row_count        = 16'(rows);
        packages_per_row = 32'(ppr);
        start            = 1'b1;
        @(negedge clk);
        k = 1;
        while (!finished && k <= budget) begin
            start = 1'b0;
            eng.prepare_my_new_input = 1'b0;
            eng.result_strobe        = 1'b0;

            if (eng.reset) begin
                resets++;
                checkOutput("no_of_multiples", BW'(eng.no_of_multiples), BW'(ppr_eff));
                checkOutput("prepares_before_reset", BW'(reals), BW'(resets - 1));
                if (resets == 1) checkOutput("reset_latency", BW'(k), BW'(1));
                else checkOutput("read_now_per_row", BW'(row_nows), BW'(ppr_eff));
                row_nows = 0;
            end
            if (mem_rd) begin
                if (rd_i == 0) checkOutput("mem_rd_latency", BW'(k), BW'(2));
                if (rd_i < exp_addr.size()) begin
                    checkOutput("mem_addr", BW'(mem_addr), BW'(exp_addr[rd_i] % (1<<AW)));
                    checkOutput("wrap_mem_rd", BW'(w_mem_rd), BW'(1));
                    checkOutput("wrap_mem_addr", BW'(w_mem_addr), BW'(exp_addr[rd_i] % (1<<AWW)));
                end else begin
                    checkOutput("mem_rd_count", BW'(rd_i + 1), BW'(exp_addr.size()));
                end
                rd_i++;
            end
            if (eng.outsider_read_now) begin
                if (nows == 0) checkOutput("read_now_latency", BW'(k), BW'(4));
                if (nows < exp_addr.size()) begin
                    checkOutput("first_row_input", eng.first_row_input, mem_a[exp_addr[nows] % (1<<AW)]);
                    checkOutput("second_row_input", eng.second_row_input, mem_b[exp_addr[nows] % (1<<AW)]);
                end else begin
                    checkOutput("read_now_count", BW'(nows + 1), BW'(exp_addr.size()));
                end
                nows++;
                row_nows++;
                if (row_nows == ppr_eff) prep_cd = 4;
                if (early_prep && nows == 1) eng.prepare_my_new_input = 1'b1;
            end
            if (result_valid) begin
                if (res_seen < exp_res.size()) begin
                    checkOutput("result_data", BW'(result_data), BW'(exp_res[res_seen]));
                    checkOutput("result_index", BW'(result_index), BW'(res_seen));
                end else begin
                    checkOutput("result_valid_count", BW'(res_seen + 1), BW'(exp_res.size()));
                end
                res_seen++;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
                checkOutput("busy_at_done", BW'(busy), BW'(1));
                checkOutput("results_at_done", BW'(res_seen), BW'(rows));
                if (rows == 0) checkOutput("done_latency", BW'(k), BW'(1));
            end
            if (done_k > 0 && k == done_k + 1) checkOutput("busy_after_done", BW'(busy), BW'(0));
            if (done_k > 0 && k == done_k + 3) finished = 1'b1;

            if (strobe_cd > 0) begin
                strobe_cd--;
                if (strobe_cd == 0) begin
                    val = fixed_res ? 32'h41800000 : EW'($urandom);
                    eng.dot_product_output = val;
                    eng.result_strobe      = 1'b1;
                    exp_res.push_back(val);
                end
            end
            if (prep_cd > 0) begin
                prep_cd--;
                if (prep_cd == 0) begin
                    eng.prepare_my_new_input = 1'b1;
                    reals++;
                    strobe_cd = 2;
                end
            end
            if (restart_mid && k == 3) begin
                start            = 1'b1;
                row_count        = 16'(rows + 3);
                packages_per_row = 32'(ppr + 2);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        eng.prepare_my_new_input = 1'b0;
        eng.result_strobe        = 1'b0;
        checkOutput("job_finished", BW'(finished), BW'(1));
        checkOutput("done_count", BW'(done_cnt), BW'(1));
        checkOutput("reset_count", BW'(resets), BW'(rows));
        checkOutput("read_now_total", BW'(nows), BW'(rows * ppr_eff));
        checkOutput("mem_rd_total", BW'(rd_i), BW'(rows * ppr_eff));
        checkOutput("result_total", BW'(res_seen), BW'(rows));
        checkOutput("no_overflow", BW'(overflow_err), BW'(0));
    endtask

    initial begin
        int seen;
        main_reset = 1'b0;
        start = 1'b0;
        row_count = '0;
        packages_per_row = '0;
        eng.prepare_my_new_input = 1'b0;
        eng.result_strobe        = 1'b0;
        eng.dot_product_output   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", BW'(busy), BW'(0));
        checkOutput("rst_done", BW'(done), BW'(0));
        checkOutput("rst_mem_rd", BW'(mem_rd), BW'(0));
        checkOutput("rst_mem_addr", BW'(mem_addr), BW'(0));
        checkOutput("rst_first_row", eng.first_row_input, BW'(0));
        checkOutput("rst_reset_out", BW'(eng.reset), BW'(0));
        checkOutput("rst_overflow", BW'(overflow_err), BW'(0));
        main_reset = 1'b1;

        $display("[TB] single row, single package, fixed operands");
        mem_a[0] = {8{32'h3F800000}};
        mem_b[0] = {8{32'h40000000}};
        applyStimulus(1, 1, 1'b0, 1'b1, 1'b0);

        $display("[TB] three rows of four packages");
        applyStimulus(3, 4, 1'b0, 1'b0, 1'b0);

        $display("[TB] zero-row job");
        applyStimulus(0, 3, 1'b0, 1'b0, 1'b0);

        $display("[TB] early prepare during hold");
        applyStimulus(2, 2, 1'b1, 1'b0, 1'b0);

        $display("[TB] address wrap on narrow twin, start ignored while busy");
        applyStimulus(2, 5, 1'b0, 1'b0, 1'b1);

        $display("[TB] zero packages per row");
        applyStimulus(1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random jobs");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] extra result strobe after done");
        @(negedge clk);
        eng.dot_product_output = 32'h12345678;
        eng.result_strobe      = 1'b1;
        @(negedge clk);
        eng.result_strobe      = 1'b0;
        checkOutput("extra_strobe_no_valid", BW'(result_valid), BW'(0));
        checkOutput("overflow_set", BW'(overflow_err), BW'(1));
        repeat (5) @(negedge clk);
        checkOutput("overflow_sticky", BW'(overflow_err), BW'(1));

        $display("[TB] reset mid-hold");
        row_count        = 16'd2;
        packages_per_row = 32'd3;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && eng.outsider_read_now !== 1'b1; i++) @(negedge clk);
        checkOutput("read_now_before_abort", BW'(eng.outsider_read_now), BW'(1));
        main_reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", BW'(busy), BW'(0));
        checkOutput("abort_mem_addr", BW'(mem_addr), BW'(0));
        checkOutput("abort_first_row", eng.first_row_input, BW'(0));
        checkOutput("abort_second_row", eng.second_row_input, BW'(0));
        checkOutput("abort_read_now", BW'(eng.outsider_read_now), BW'(0));
        checkOutput("abort_result_data", BW'(result_data), BW'(0));
        checkOutput("abort_result_index", BW'(result_index), BW'(0));
        checkOutput("abort_overflow", BW'(overflow_err), BW'(0));
        main_reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || mem_rd || eng.reset || busy) seen++;
        end
        checkOutput("idle_after_abort", BW'(seen), BW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_row_feeder.md
# dot_product_row_feeder

Producer-side driver for the eight-unit dot-product engine: reads paired row packages (`no_of_units` elements each) from two synchronous-read memories and streams them into the engine's row interface. It issues the per-row reset pulse with `no_of_multiples`, and paces packages with `outsider_read_now`. It waits for `prepare_my_new_input` before moving to the next row, collects each row result, and signals `done` after the last row. It sits between the matrix/vector storage and the dot-product engine inside the solver datapath.

## Interface
- `no_of_units`, 8, elements per package
- `element_width`, 32, bits per element (IEEE-754 single)
- `addr_width`, 10, memory address width
- `clk`  in  1  system clock, all logic on posedge
- `main_reset`  in  1  synchronous, active-low reset
- `start`  in  1  pulse; begins a job when sampled in IDLE
- `row_count`  in  16  rows in job; latched on accepted `start`
- `packages_per_row`  in  32  packages per row; latched on accepted `start`
- `mem_addr`  out  `addr_width`  shared read address for both memories
- `mem_rd`  out  1  read strobe; data valid exactly 1 cycle later
- `mem_first_data`  in  `element_width*no_of_units`  first-row package
- `mem_second_data`  in  `element_width*no_of_units`  second-row package
- `first_row_input`  out  `element_width*no_of_units`  registered package to engine
- `second_row_input`  out  `element_width*no_of_units`  registered package to engine
- `outsider_read_now`  out  1  one-cycle package-valid pulse
- `reset`  out  1  one-cycle row-start pulse to engine (active-high)
- `no_of_multiples`  out  32  packages in current row; valid while `reset` is high
- `prepare_my_new_input`  in  1  engine accepted last package of row
- `result_strobe`  in  1  one-cycle pulse: `dot_product_output` valid
- `dot_product_output`  in  `element_width`  row result from engine
- `result_valid`  out  1  one-cycle pulse per captured result
- `result_data`  out  `element_width`  captured result
- `result_index`  out  16  row index of `result_data` (0-based)
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse when all `row_count` results captured
- `overflow_err`  out  1  sticky; extra `result_strobe` after job complete

## Operation
- Reset (`main_reset`=0 at posedge): state IDLE; every output 0, including data buses and `mem_addr`; counters cleared; `overflow_err` cleared. Reset mid-job aborts with no `done`.
- `packages_per_row` of 0 is latched as 1. `row_count` of 0 goes from IDLE directly to DONE: `done` pulses the cycle after `start`, `busy` high for 1 cycle.
- `start` while not IDLE is ignored.
- FSM:
  - IDLE -> ROW_RESET on `start`.
  - ROW_RESET: `reset`=1 and `no_of_multiples`=latched value for 1 cycle. -> FETCH.
  - FETCH: `mem_rd`=1, `mem_addr`=address counter. -> LOAD.
  - LOAD: register memory data onto `first_row_input` / `second_row_input`; address counter +1, wrapping modulo 2^`addr_width`. -> HOLD.
  - HOLD: 3 cycles; `outsider_read_now`=1 in the first only. Then -> FETCH if packages remain in the row, else -> WAIT_ROW.
  - WAIT_ROW: `prepare_my_new_input` is sampled only in this state. On it: -> ROW_RESET if rows remain, else -> DRAIN.
  - DRAIN: waits until result count equals `row_count`. -> DONE.
  - DONE: `done`=1 for 1 cycle. -> IDLE.
- Result capture runs in every non-IDLE state and is independent of the FSM:
  - On `result_strobe`: `result_data` takes `dot_product_output`, `result_index` takes the result count, `result_valid` pulses next cycle, count +1.
  - A strobe when count already equals `row_count`, or in IDLE, sets `overflow_err` and is otherwise ignored.
- The address counter is not reset between rows: row r, package p is read at `r*packages_per_row + p`.

## Timing
- Package period: 5 cycles (FETCH, LOAD, 3×HOLD). Package data is stable from the first HOLD cycle through the next LOAD edge, at least 4 cycles, covering the engine's two-half capture.
- `start` at edge t: `reset` high in cycle t+1, first `mem_rd` at t+2, first `outsider_read_now` at t+4.
- Row overhead: 1 ROW_RESET cycle plus WAIT_ROW dwell.
- `result_valid` follows `result_strobe` by exactly 1 cycle. A strobe coinciding with the DONE transition is still captured.
- `busy` falls the cycle after the `done` pulse.

## Structure
- Shared package: FSM state enum, `HOLD_CYCLES`=3, default widths.
- One sub-module, `row_result_collector`: strobe capture, result count, `overflow_err`.

## Test plan
- `row_count`=1, `packages_per_row`=1, memory[0]=all 1.0 / all 2.0, engine model strobes 16.0:
  - `reset` at t+1, `outsider_read_now` at t+4, `result_data`=0x41800000, `result_index`=0, `done` once.
- `row_count`=3, `packages_per_row`=4: `mem_addr` sequence 0..11, 4 `read_now` pulses per row, rows separated by `prepare_my_new_input`, results indexed 0,1,2.
- `row_count`=0 -> `done` at t+1, no `reset`, no `mem_rd`.
- `prepare_my_new_input` asserted during HOLD of row 0 package 1 of 2 -> ignored; row advances only on the later pulse in WAIT_ROW.
- `addr_width`=3, `packages_per_row`=5, `row_count`=2: addresses 0..7,0,1 (wrap).
- `main_reset` low mid-HOLD -> all outputs 0 next cycle, IDLE. Extra `result_strobe` after `done` -> `overflow_err`=1 and stays 1 until reset.
